// File: rtl/ifu_pkg.sv
// Shared constants and helpers for the instruction-fetch prefetch unit.
package ifu_pkg;

  localparam int INSMEMSTEP = 4;

  // Bits needed to hold any value in 0..max_val.
  function automatic int ctr_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// Memory-side and decode-side handshake bundle of the fetch unit.
interface ifu_prefetch_if #(
  parameter int DATAWIDTH = 32
);
  logic                 IFU_Insmem_Read;
  logic [DATAWIDTH-1:0] IFU_Insmem_Addr_OutBUS;
  logic                 IFU_Insmem_Ready_In;
  logic [DATAWIDTH-1:0] IFU_Insmem_Readdata_InBUS;
  logic                 IFU_Insmem_Readdatavalid_In;
  logic                 IFU_Redirect_In;
  logic [DATAWIDTH-1:0] IFU_Redirect_Addr_InBUS;
  logic                 IFU_Ins_Valid_Out;
  logic                 IFU_Ins_Ready_In;
  logic [DATAWIDTH-1:0] IFU_Ins_OutBUS;
  logic [DATAWIDTH-1:0] IFU_Ins_Pc_OutBUS;

  modport master (
    output IFU_Insmem_Read, IFU_Insmem_Addr_OutBUS,
    input  IFU_Insmem_Ready_In, IFU_Insmem_Readdata_InBUS, IFU_Insmem_Readdatavalid_In,
    input  IFU_Redirect_In, IFU_Redirect_Addr_InBUS,
    output IFU_Ins_Valid_Out, IFU_Ins_OutBUS, IFU_Ins_Pc_OutBUS,
    input  IFU_Ins_Ready_In
  );

  modport slave (
    input  IFU_Insmem_Read, IFU_Insmem_Addr_OutBUS,
    output IFU_Insmem_Ready_In, IFU_Insmem_Readdata_InBUS, IFU_Insmem_Readdatavalid_In,
    output IFU_Redirect_In, IFU_Redirect_Addr_InBUS,
    input  IFU_Ins_Valid_Out, IFU_Ins_OutBUS, IFU_Ins_Pc_OutBUS,
    output IFU_Ins_Ready_In
  );
endinterface

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO; flush dominates push/pop, head comes straight from storage flops.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              head,
  output logic [ctr_width(DEPTH)-1:0]   count,
  output logic                          empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = ctr_width(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & ((int'(count_reg) < DEPTH) | do_pop);

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= din;
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;
endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: credit-limited read issue, in-order response capture,
// prefetch buffer toward decode and redirect with discard of in-flight reads.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int                   DATAWIDTH       = 32,
  parameter int                   DEPTH           = 4,
  parameter int                   MAX_OUTSTANDING = 2,
  parameter logic [DATAWIDTH-1:0] RESET_PC        = '0
) (
  input  logic           IFU_Clk_in,
  input  logic           IFU_Reset_in,
  ifu_prefetch_if.master bus
);
  localparam int OW = ctr_width(MAX_OUTSTANDING);
  localparam int CW = ctr_width(DEPTH);

  typedef struct packed {
    logic [DATAWIDTH-1:0] ins;
    logic [DATAWIDTH-1:0] pc;
  } entry_t;

  logic [DATAWIDTH-1:0] fetch_pc_reg;
  logic [DATAWIDTH-1:0] resp_pc_reg;
  logic [DATAWIDTH-1:0] target;
  logic [OW-1:0]        outstanding_reg;
  logic [OW-1:0]        discard_reg;
  logic [CW-1:0]        count;
  logic                 empty;
  entry_t               push_entry;
  entry_t               head;
  logic                 read, accept, rdv, redirect, drop, push, pop, valid;
  logic                 unused_addr_bits;

  assign redirect         = bus.IFU_Redirect_In;
  assign rdv              = bus.IFU_Insmem_Readdatavalid_In;
  assign target           = {bus.IFU_Redirect_Addr_InBUS[DATAWIDTH-1:2], 2'b00};
  assign unused_addr_bits = ^bus.IFU_Redirect_Addr_InBUS[1:0];

  // Reserving a buffer slot per in-flight read means a response can always be stored.
  assign read   = ~IFU_Reset_in & ~redirect
                & (int'(outstanding_reg) < MAX_OUTSTANDING)
                & (int'(outstanding_reg) + int'(count) < DEPTH);
  assign accept = read & bus.IFU_Insmem_Ready_In;
  assign drop   = rdv & (discard_reg != '0);
  assign push   = rdv & ~drop & ~redirect;
  assign pop    = ~empty & bus.IFU_Ins_Ready_In & ~redirect;
  assign valid  = ~empty & ~IFU_Reset_in;

  assign push_entry = '{ins: bus.IFU_Insmem_Readdata_InBUS, pc: resp_pc_reg};

  ifu_fifo #(
    .WIDTH (2 * DATAWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (IFU_Clk_in),
    .srst  (IFU_Reset_in),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (push_entry),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge IFU_Clk_in) begin
    if (IFU_Reset_in) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else if (redirect) begin
      // Every read still unanswered after this cycle belongs to the old path.
      fetch_pc_reg    <= target;
      resp_pc_reg     <= target;
      outstanding_reg <= outstanding_reg - OW'(rdv);
      discard_reg     <= outstanding_reg - OW'(rdv);
    end else begin
      if (accept) fetch_pc_reg <= fetch_pc_reg + DATAWIDTH'(INSMEMSTEP);
      outstanding_reg <= outstanding_reg + OW'(accept) - OW'(rdv);
      if (drop)      discard_reg <= discard_reg - OW'(1);
      else if (push) resp_pc_reg <= resp_pc_reg + DATAWIDTH'(INSMEMSTEP);
    end
  end

  always_ff @(posedge IFU_Clk_in) begin
    if (!IFU_Reset_in) begin
      assert (int'(outstanding_reg) + int'(count) <= DEPTH);
      assert (discard_reg <= outstanding_reg);
      assert (!(rdv && outstanding_reg == '0));
    end
  end

  assign bus.IFU_Insmem_Read        = read;
  assign bus.IFU_Insmem_Addr_OutBUS = IFU_Reset_in ? RESET_PC : fetch_pc_reg;
  assign bus.IFU_Ins_Valid_Out      = valid;
  assign bus.IFU_Ins_OutBUS         = valid ? head.ins : '0;
  assign bus.IFU_Ins_Pc_OutBUS      = valid ? head.pc  : '0;
endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised instruction-fetch unit; next-generation replacement for the fixed PC/instruction-register fetch path of the RV32I core.
- Decouples the core from a variable-latency instruction memory using a request/accept handshake, in-order responses, up to MAX_OUTSTANDING reads in flight and a DEPTH-entry prefetch buffer.
- Presents instructions to decode through a valid/ready handshake, each tagged with its PC.
- Supports branch/jump redirect: flushes the buffer and discards in-flight responses.

Parameters:
- DATAWIDTH, 32: instruction, address and PC width.
- DEPTH, 4: prefetch buffer entries; power of 2, >= 2.
- MAX_OUTSTANDING, 2: maximum accepted, unanswered memory reads; 1..DEPTH.
- RESET_PC, 32'h0: fetch address after reset.

Ports:
- IFU_Clk_in  in  1  clock; all logic on rising edge.
- IFU_Reset_in  in  1  reset, synchronous, active-high.
- IFU_Insmem_Read  out  1  read request valid.
- IFU_Insmem_Addr_OutBUS  out  DATAWIDTH  read address; word aligned.
- IFU_Insmem_Ready_In  in  1  memory accepts the request this cycle.
- IFU_Insmem_Readdata_InBUS  in  DATAWIDTH  response data.
- IFU_Insmem_Readdatavalid_In  in  1  response valid; responses return in request order.
- IFU_Redirect_In  in  1  branch/jump taken.
- IFU_Redirect_Addr_InBUS  in  DATAWIDTH  redirect target.
- IFU_Ins_Valid_Out  out  1  instruction available.
- IFU_Ins_Ready_In  in  1  decode consumes.
- IFU_Ins_OutBUS  out  DATAWIDTH  instruction.
- IFU_Ins_Pc_OutBUS  out  DATAWIDTH  PC of IFU_Ins_OutBUS.

Behaviour:
- Clock and reset: single clock IFU_Clk_in; reset IFU_Reset_in is synchronous and active-high.
- Reset state:
  - fetch_pc = resp_pc = RESET_PC; outstanding = 0; discard = 0; buffer empty.
  - IFU_Insmem_Read = 0 and IFU_Ins_Valid_Out = 0 while reset is asserted.
  - IFU_Insmem_Addr_OutBUS = RESET_PC.
  - IFU_Ins_OutBUS and IFU_Ins_Pc_OutBUS are forced to 0 whenever Valid = 0.
- Credit rule:
  - Read = ~reset & ~IFU_Redirect_In & (outstanding < MAX_OUTSTANDING) & (outstanding + count < DEPTH).
  - The buffer therefore never overflows, so no full-drop path exists.
- Request handshake:
  - accept = Read & Ready.
  - Addr = fetch_pc, held stable while Read = 1 and Ready = 0.
  - On accept: fetch_pc += 4 and outstanding++.
- Response:
  - On Readdatavalid, outstanding--.
  - If discard > 0: discard-- and drop the data.
  - Otherwise push {data, resp_pc} and resp_pc += 4.
  - Accept and response in the same cycle leave outstanding unchanged.
- Output:
  - Valid = buffer non-empty; head registered.
  - Pop on Valid & IFU_Ins_Ready_In.
  - A response pushed in cycle N is visible at the earliest in cycle N+1.
  - Push and pop in the same cycle are permitted at any occupancy.
- Redirect (priority over pop, push and accept):
  - target = {addr[DATAWIDTH-1:2], 2'b00}; fetch_pc = resp_pc = target.
  - Buffer flushed; no request issued in this cycle.
  - discard = outstanding - Readdatavalid, i.e. every still-unanswered read, including ones already being discarded; a response arriving in the redirect cycle is dropped.
  - Back-to-back redirects: the last one wins; discard recomputes each time.
- Latency and throughput:
  - Zero-wait memory with 1-cycle read latency: request accepted cycle 0 -> response cycle 1 -> Valid cycle 2.
  - Sustained 1 instruction/cycle when DEPTH >= MAX_OUTSTANDING + 1 and Ready = 1.
- Counters:
  - outstanding and discard are clog2(MAX_OUTSTANDING+1) bits; count is clog2(DEPTH+1) bits.
  - PC arithmetic wraps modulo 2^DATAWIDTH.
- Reset mid-operation:
  - All state returns to reset values.
  - Instruction memory shares this reset; a response in the cycle after reset is a protocol violation (bench assertion).
- Assertions:
  - outstanding + count <= DEPTH.
  - discard <= outstanding.
  - No Readdatavalid when outstanding = 0.

Decomposition:
- Package ifu_pkg:
  - INSMEMSTEP = 4.
  - Counter-width functions (clog2-based).
  - Entry struct {ins, pc}.
- Sub-module ifu_fifo: synchronous FIFO, width 2*DATAWIDTH, depth DEPTH.
  - Ports: push, pop, flush (flush dominant), count, empty.
  - Registered head output.
- Top level holds fetch_pc, resp_pc, outstanding, discard and the credit/request logic.

Test Plan:
- Streaming (zero-wait, 1-cycle latency, Ready = Ins_Ready = 1) after reset -> requests at 0x0, 0x4, 0x8...; Valid first in cycle 2 with PC 0x0; then one instruction per cycle, PCs consecutive.
- Backpressure (IFU_Ins_Ready_In = 0, DEPTH = 4) -> exactly 4 requests (0x0..0xC), then Read = 0; after release, instructions emerge in order 0x0..0xC and fetch resumes at 0x10.
- Memory stall (Ready = 0 for 3 cycles with request pending at 0x8) -> Addr = 0x8 and Read = 1 stable for all 3 cycles; one accept only.
- Redirect with 2 outstanding and 1 buffered, target 0x103 -> buffer emptied next cycle; both late responses dropped (Valid stays 0); next request and first valid PC are 0x100.
- Redirect coincident with Readdatavalid and pop -> the arriving response is dropped, the pop has no effect, discard = outstanding - 1; first delivered PC = target.
- Reset asserted for 1 cycle mid-stream with 2 outstanding -> next cycle Valid = 0, Read = 0, Addr = RESET_PC; after release, fetch restarts at RESET_PC.
